filt_requant: RTL and testbench
===============================

// Module: filt_requant
// PURPOSE
//  Downstream stage of the filt_mac MAC FIR filter. Captures each full-precision filter result on the filter's done strobe.
//  Optionally decimates the results, then rounds and saturates them to the system sample width.
//  Buffers the samples in a small FIFO and hands them to the consumer over a valid/ready handshake.
// PARAMETERS
//  gp_inp_width   37  width of i_data (filter output width: data+coeff+length)
//  gp_oup_width   16  width of o_data; must be < gp_inp_width-gp_shift+1
//  gp_shift       12  LSBs discarded by rounding; 0 = no rounding
//  gp_dec_factor   1  keep 1 of every gp_dec_factor filter results (>=1)
//  gp_fifo_depth   4  FIFO entries; power of 2, >=2
// PORTS
//  i_clk      in   1                        clock
//  i_rst_an   in   1                        reset, asynchronous, active-low
//  i_ena      in   1                        qualifies i_done (same enable as the upstream filter)
//  i_done     in   1                        upstream done flag; one frame end per cycle high with i_ena
//  i_data     in   gp_inp_width (signed)    upstream result; valid the cycle after i_done&i_ena
//  i_clr_ovf  in   1                        synchronous clear of o_ovf
//  i_ready    in   1                        consumer accepts o_data this cycle
//  o_data     out  gp_oup_width (signed)    FIFO head (first-word fall-through); 0 when empty
//  o_valid    out  1                        FIFO not empty
//  o_ovf      out  1                        sticky flag: a saturation has occurred
//  o_drop     out  1                        1-cycle pulse: sample lost, FIFO full
//  o_level    out  $clog2(gp_fifo_depth)+1  current FIFO occupancy
// BEHAVIOUR
//  Reset: all registers cleared. o_data=0, o_valid=0, o_ovf=0, o_drop=0, o_level=0.
//   Reset also clears the decimation counter and the FIFO pointers.
//   A reset mid-operation discards the FIFO contents and any in-flight sample.
//  Edge E0: r_done_d <= i_ena & i_done. i_ena gates only this qualification; all later stages always run.
//  Edge E1 (r_done_d=1): r_dec_cnt advances 0..gp_dec_factor-1 and wraps.
//   The sample is kept only when r_dec_cnt==0 before the increment, so the first result after reset is kept.
//   A kept sample is rounded, saturated, and loaded into r_q; r_q_vld pulses high for 1 cycle.
//  Rounding: round-half-up. tmp = i_data + 2^(gp_shift-1), computed at gp_inp_width+1 bits.
//   The result is then arithmetic-shifted right by gp_shift.
//  Saturation: clamp to [-2^(gp_oup_width-1), 2^(gp_oup_width-1)-1].
//   Any clamp sets o_ovf on E1. If set and i_clr_ovf coincide, set wins.
//  Edge E2 (r_q_vld=1): r_q is written to the FIFO.
//   Latency when the FIFO is empty: o_valid rises after E2, i.e. 3 edges after i_done is sampled.
//  FIFO full and no read this cycle: the write is dropped, o_drop=1 for one cycle, contents unchanged.
//  FIFO full with a read in the same cycle: the write is accepted and o_level stays at gp_fifo_depth.
//  Read: occurs on o_valid & i_ready. The head advances at the edge; i_ready while empty is ignored.
//  Read and write in the same cycle when not full: o_level is unchanged.
//  Pointers use an extra wrap bit. full: level==depth. empty: level==0.
//  i_done high on consecutive enabled cycles: each enabled cycle is a separate frame, and the pipeline accepts 1/cycle.
// TESTING
//  Round/sat: shift=12, out=16. Check these i_data -> o_data mappings:
//   6144 -> 2
//   -2048 -> 0
//   -2049 -> -1
//   2^27 -> 32767 with o_ovf=1
//   -2^28 -> -32768
//  Latency: empty FIFO, i_ready=1, one i_done pulse with i_ena=1.
//   o_valid must be high exactly 3 edges later, for 1 cycle.
//  Decimation: gp_dec_factor=3, 9 done pulses with i_data=1<<12,2<<12..9<<12.
//   Output must be 1,4,7.
//  Full/drop: depth 4, i_ready=0, 6 samples.
//   Expect o_level=4, o_drop pulsed twice, then i_ready=1 drains the first 4 in order.
//  Full + read: level=4 with a write and a read in the same cycle.
//   Expect no o_drop, o_level=4, and the new sample at the tail.
//  Sticky/reset: saturate then pulse i_clr_ovf -> o_ovf=0.
//   Assert i_rst_an=0 with 3 entries queued -> o_valid=0 and o_level=0 immediately.

Source files
------------

// File: rtl/filt_requant.sv
// filt_requant: captures filt_mac results, decimates, rounds/saturates and queues them.
// Latency: o_valid rises 3 edges after i_done&i_ena is sampled (empty FIFO).
// Backpressure: i_ready stalls the FIFO head; new samples drop (o_drop) while full without a read.

// Generic first-word fall-through FIFO with extra pointer wrap bit.
// Latency: write visible on rd_dat the edge after wr_vld; read advances head at the edge.
// Backpressure: write refused when full unless a read happens in the same cycle; wr_drop pulses next cycle.
module filt_requant_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_an,
    input  logic                     wr_vld,
    input  logic [DW-1:0]            wr_dat,
    output logic                     wr_drop,
    input  logic                     rd_rdy,
    output logic                     rd_vld,
    output logic [DW-1:0]            rd_dat,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic          full;
    logic          empty;
    logic          rd_en;
    logic          wr_en;

    assign level  = wptr - rptr;
    assign full   = (level == (AW+1)'(DEPTH));
    assign empty  = (level == '0);
    assign rd_vld = !empty;
    assign rd_dat = empty ? '0 : mem[rptr[AW-1:0]];
    assign rd_en  = rd_vld & rd_rdy;
    // A simultaneous read frees the slot, so a full FIFO still accepts the write.
    assign wr_en  = wr_vld & (!full | rd_en);

    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            wptr    <= '0;
            rptr    <= '0;
            wr_drop <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            wr_drop <= wr_vld & full & ~rd_en;
            if (wr_en) begin
                mem[wptr[AW-1:0]] <= wr_dat;
                wptr              <= wptr + 1'b1;
            end
            if (rd_en) rptr <= rptr + 1'b1;
        end
    end
endmodule

// Requantiser top: done qualification, decimation, round-half-up + saturation, output FIFO.
// Latency: 3 edges from sampled i_done to o_valid when the FIFO is empty.
// Backpressure: valid/ready on the output; overflow of the FIFO drops the newest sample.
module filt_requant #(
    parameter int gp_inp_width  = 37,
    parameter int gp_oup_width  = 16,
    parameter int gp_shift      = 12,
    parameter int gp_dec_factor = 1,
    parameter int gp_fifo_depth = 4
) (
    input  logic                              i_clk,
    input  logic                              i_rst_an,
    input  logic                              i_ena,
    input  logic                              i_done,
    input  logic signed [gp_inp_width-1:0]    i_data,
    input  logic                              i_clr_ovf,
    input  logic                              i_ready,
    output logic signed [gp_oup_width-1:0]    o_data,
    output logic                              o_valid,
    output logic                              o_ovf,
    output logic                              o_drop,
    output logic [$clog2(gp_fifo_depth):0]    o_level
);
    localparam int CW = (gp_dec_factor > 1) ? $clog2(gp_dec_factor) : 1;
    localparam int RW = gp_inp_width - gp_shift + 1;
    localparam logic signed [gp_oup_width-1:0] c_max = {1'b0, {(gp_oup_width-1){1'b1}}};
    localparam logic signed [gp_oup_width-1:0] c_min = {1'b1, {(gp_oup_width-1){1'b0}}};

    logic                           r_done_d;
    logic [CW-1:0]                  r_dec_cnt;
    logic signed [gp_oup_width-1:0] r_q;
    logic                           r_q_vld;
    logic                           r_ovf;
    logic signed [gp_inp_width:0]   rnd_sum;
    logic signed [RW-1:0]           rnd_q;
    logic                           sat_hi;
    logic                           sat_lo;
    logic signed [gp_oup_width-1:0] sat_q;
    logic                           keep;
    logic [gp_oup_width-1:0]        fifo_dat;

    generate
        if (gp_shift > 0) begin : g_round
            localparam logic [gp_inp_width:0] c_half = (gp_inp_width+1)'(1) << (gp_shift-1);
            assign rnd_sum = {i_data[gp_inp_width-1], i_data} + c_half;
        end else begin : g_noround
            assign rnd_sum = {i_data[gp_inp_width-1], i_data};
        end
    endgenerate

    assign rnd_q  = RW'(rnd_sum >>> gp_shift);
    // Out of range whenever the bits above the output sign bit disagree with the sign.
    assign sat_hi = !rnd_q[RW-1] &&  (|rnd_q[RW-2:gp_oup_width-1]);
    assign sat_lo =  rnd_q[RW-1] && !(&rnd_q[RW-2:gp_oup_width-1]);
    assign sat_q  = sat_hi ? c_max : (sat_lo ? c_min : rnd_q[gp_oup_width-1:0]);
    assign keep   = (r_dec_cnt == '0);

    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            r_done_d  <= 1'b0;
            r_dec_cnt <= '0;
            r_q       <= '0;
            r_q_vld   <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_done_d <= i_ena & i_done;
            r_q_vld  <= r_done_d & keep;
            if (r_done_d) begin
                r_dec_cnt <= (r_dec_cnt == CW'(gp_dec_factor-1)) ? '0 : r_dec_cnt + 1'b1;
                if (keep) r_q <= sat_q;
            end
            if (r_done_d && keep && (sat_hi || sat_lo)) r_ovf <= 1'b1;
            else if (i_clr_ovf)                         r_ovf <= 1'b0;
        end
    end

    assign o_ovf = r_ovf;

    filt_requant_fifo #(
        .DW    (gp_oup_width),
        .DEPTH (gp_fifo_depth)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_rst_an (i_rst_an),
        .wr_vld   (r_q_vld),
        .wr_dat   (r_q),
        .wr_drop  (o_drop),
        .rd_rdy   (i_ready),
        .rd_vld   (o_valid),
        .rd_dat   (fifo_dat),
        .level    (o_level)
    );

    assign o_data = fifo_dat;
endmodule

// File: tb/tb_filt_requant.sv
// Bench for filt_requant: directed round/sat, latency, decimation, full/drop and reset cases,
// then random traffic against a queue-based reference model.
module tb_filt_requant;
    localparam int IW    = 37;
    localparam int OW    = 16;
    localparam int DEPTH = 4;

    logic                 i_clk     = 1'b0;
    logic                 i_rst_an  = 1'b0;
    logic                 i_ena     = 1'b0;
    logic                 i_done    = 1'b0;
    logic                 i_clr_ovf = 1'b0;
    logic                 i_ready   = 1'b0;
    logic signed [IW-1:0] i_data    = '0;

    logic signed [OW-1:0] o_data;
    logic                 o_valid, o_ovf, o_drop;
    logic [2:0]           o_level;
    logic signed [OW-1:0] d3_data;
    logic                 d3_valid, d3_ovf, d3_drop;
    logic [2:0]           d3_level;

    filt_requant dut (
        .i_clk(i_clk), .i_rst_an(i_rst_an), .i_ena(i_ena), .i_done(i_done),
        .i_data(i_data), .i_clr_ovf(i_clr_ovf), .i_ready(i_ready),
        .o_data(o_data), .o_valid(o_valid), .o_ovf(o_ovf), .o_drop(o_drop), .o_level(o_level)
    );

    filt_requant #(.gp_dec_factor(3)) dut3 (
        .i_clk(i_clk), .i_rst_an(i_rst_an), .i_ena(i_ena), .i_done(i_done),
        .i_data(i_data), .i_clr_ovf(i_clr_ovf), .i_ready(i_ready),
        .o_data(d3_data), .o_valid(d3_valid), .o_ovf(d3_ovf), .o_drop(d3_drop), .o_level(d3_level)
    );

    always #5 i_clk = ~i_clk;

    int errs = 0;
    int checks = 0;
    int drops_seen = 0;

    // Reference model state: queue contents, sample awaiting its FIFO write, frame-end seen last cycle.
    logic signed [OW-1:0] m_q[$];
    bit                   m_wr_pend;
    logic signed [OW-1:0] m_wr_val;
    bit                   m_done_prev;
    bit                   m_ovf;
    bit                   m_drop;

    function automatic longint ref_q(input longint x, output bit sat);
        longint t, q;
        t = x + 2048;
        if (t >= 0) q = t / 4096;
        else        q = -((-t + 4095) / 4096);
        sat = 1'b0;
        if (q > 32767)       begin q = 32767;  sat = 1'b1; end
        else if (q < -32768) begin q = -32768; sat = 1'b1; end
        return q;
    endfunction

    function automatic longint rnd_data();
        longint v;
        case ($urandom_range(0, 3))
            0:       v = longint'($urandom_range(0, 1 << 17)) - (1 << 16);
            1:       v = longint'($urandom_range(0, 1 << 29)) - (1 << 28);
            2:       v = longint'($signed($urandom)) * 16;
            default: v = longint'($urandom_range(0, 60000)) * 4096 - 2048 - longint'($urandom_range(0, 1))
                         - (longint'($urandom_range(0, 1)) * 120000 * 4096);
        endcase
        return v;
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_wr_pend   = 1'b0;
        m_wr_val    = '0;
        m_done_prev = 1'b0;
        m_ovf       = 1'b0;
        m_drop      = 1'b0;
    endtask

    // Advance model and DUT by one clock, then compare every observable output.
    task automatic cyc();
        bit rd, full, sat, new_pend;
        logic signed [OW-1:0] new_val;
        rd       = (m_q.size() > 0) && i_ready;
        full     = (m_q.size() == DEPTH);
        m_drop   = m_wr_pend && full && !rd;
        new_pend = 1'b0;
        new_val  = '0;
        sat      = 1'b0;
        if (m_done_prev) begin
            new_val  = OW'(ref_q(longint'(i_data), sat));
            new_pend = 1'b1;
        end
        if (m_done_prev && sat) m_ovf = 1'b1;
        else if (i_clr_ovf)     m_ovf = 1'b0;
        if (rd) void'(m_q.pop_front());
        if (m_wr_pend && !m_drop) m_q.push_back(m_wr_val);
        m_wr_pend   = new_pend;
        m_wr_val    = new_val;
        m_done_prev = i_ena & i_done;
        @(posedge i_clk);
        #1;
        if (o_drop) drops_seen++;
        chk("valid", o_valid, m_q.size() > 0);
        chk("data", o_data, (m_q.size() > 0) ? m_q[0] : 16'sd0);
        chk("level", o_level, m_q.size());
        chk("ovf", o_ovf, m_ovf);
        chk("drop", o_drop, m_drop);
    endtask

    task automatic send(input longint v);
        i_ena  = 1'b1;
        i_done = 1'b1;
        cyc();
        i_done = 1'b0;
        i_data = IW'(v);
        cyc();
    endtask

    task automatic do_reset();
        i_done    = 1'b0;
        i_clr_ovf = 1'b0;
        i_rst_an  = 1'b0;
        #1;
        model_clear();
        #1;
        i_rst_an  = 1'b1;
    endtask

    longint rs_in [4] = '{-2048, -2049, 64'sd134217728, -64'sd268435456};
    longint rs_exp[4] = '{0, -1, 32767, -32768};

    initial begin
        model_clear();
        #12;
        chk("rst_data", o_data, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_ovf", o_ovf, 0);
        chk("rst_drop", o_drop, 0);
        chk("rst_level", o_level, 0);
        @(posedge i_clk);
        #1;
        i_rst_an = 1'b1;
        i_ena    = 1'b1;
        i_ready  = 1'b1;

        // Latency and first rounding case
        send(6144);
        chk("lat_pre", o_valid, 0);
        cyc();
        chk("lat_valid", o_valid, 1);
        chk("rs_6144", o_data, 2);
        cyc();
        chk("lat_pulse", o_valid, 0);

        for (int k = 0; k < 4; k++) begin
            send(rs_in[k]);
            cyc();
            chk("round_sat", o_data, rs_exp[k]);
            cyc();
        end
        chk("ovf_sticky", o_ovf, 1);
        i_clr_ovf = 1'b1;
        cyc();
        i_clr_ovf = 1'b0;
        chk("ovf_clr", o_ovf, 0);

        // Clear coinciding with a saturating capture: set wins
        i_done = 1'b1;
        cyc();
        i_done    = 1'b0;
        i_data    = IW'(64'sd1 << 30);
        i_clr_ovf = 1'b1;
        cyc();
        i_clr_ovf = 1'b0;
        chk("ovf_set_wins", o_ovf, 1);
        cyc();
        cyc();

        // Decimation by 3 with back-to-back frame ends
        do_reset();
        i_ready = 1'b0;
        for (int j = 0; j < 10; j++) begin
            i_done = (j < 9);
            i_data = IW'(longint'(j) << 12);
            cyc();
        end
        cyc();
        cyc();
        chk("dec_level", d3_level, 3);
        i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("dec_out", d3_data, 1 + 3 * k);
            cyc();
        end
        chk("dec_empty", d3_valid, 0);
        cyc();

        // Full and drop
        do_reset();
        i_ready    = 1'b0;
        drops_seen = 0;
        for (int k = 0; k < 6; k++) send(longint'(10 + k) << 12);
        cyc();
        cyc();
        chk("drop_count", drops_seen, 2);
        chk("full_level", o_level, 4);
        i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("drain_order", o_data, 10 + k);
            cyc();
        end
        chk("drain_empty", o_valid, 0);

        // Full with simultaneous read and write
        do_reset();
        i_ready = 1'b0;
        for (int k = 0; k < 4; k++) send(longint'(20 + k) << 12);
        cyc();
        chk("fr_pre_level", o_level, 4);
        send(longint'(24) << 12);
        i_ready = 1'b1;
        cyc();
        chk("fr_drop", o_drop, 0);
        chk("fr_level", o_level, 4);
        for (int k = 1; k <= 4; k++) begin
            chk("fr_order", o_data, 20 + k);
            cyc();
        end

        // Random traffic, first with a free-flowing consumer then a congested one
        do_reset();
        repeat (300) begin
            i_ena     = ($urandom_range(0, 3) != 0);
            i_done    = ($urandom_range(0, 2) == 0);
            i_data    = IW'(rnd_data());
            i_ready   = ($urandom_range(0, 3) != 0);
            i_clr_ovf = ($urandom_range(0, 15) == 0);
            cyc();
        end
        repeat (300) begin
            i_ena     = 1'b1;
            i_done    = ($urandom_range(0, 1) == 0);
            i_data    = IW'(rnd_data());
            i_ready   = ($urandom_range(0, 3) == 0);
            i_clr_ovf = ($urandom_range(0, 31) == 0);
            cyc();
        end
        i_clr_ovf = 1'b0;
        i_done    = 1'b0;

        // Reset with entries queued and one sample in flight
        do_reset();
        i_ready = 1'b0;
        for (int k = 0; k < 3; k++) send(longint'(30 + k) << 12);
        cyc();
        chk("pre_rst_level", o_level, 3);
        i_done = 1'b1;
        cyc();
        i_done   = 1'b0;
        i_data   = IW'(longint'(33) << 12);
        i_rst_an = 1'b0;
        #1;
        chk("arst_valid", o_valid, 0);
        chk("arst_level", o_level, 0);
        model_clear();
        #1;
        i_rst_an = 1'b1;
        repeat (4) cyc();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
